// File: rtl/rat_pkg.sv
// rtl/rat_pkg.sv - shared constants, types and latency helper for the rational mul/div unit
package rat_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int RAT_WIDTH = 32;

    typedef struct packed {
        logic signed [RAT_WIDTH-1:0] num;
        logic signed [RAT_WIDTH-1:0] den;
    } rat_t;

    typedef struct packed {
        logic signed [2*RAT_WIDTH-1:0] num;
        logic signed [2*RAT_WIDTH-1:0] den;
    } rat_wide_t;

    // Input register + multiplier stages + normalise/output register.
    function automatic int rat_latency(input int mul_stages);
        return mul_stages + 2;
    endfunction

endpackage

// File: rtl/rat_mul_pipe.sv
// rtl/rat_mul_pipe.sv - signed full-width pipelined multiplier with a shared stage enable
module rat_mul_pipe
    import rat_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] p
);

    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] p_d [STAGES];
    logic signed [2*WIDTH-1:0] p_q [STAGES];

    // Product enters the first register; later registers only retime it so the
    // multiply can be spread across them by the synthesis retimer.
    always_comb begin
        a_ext = {{WIDTH{a[WIDTH-1]}}, a};
        b_ext = {{WIDTH{b[WIDTH-1]}}, b};
        for (int i = 0; i < STAGES; i++) begin
            p_d[i] = p_q[i];
        end
        if (en) begin
            p_d[0] = a_ext * b_ext;
            for (int i = 1; i < STAGES; i++) begin
                p_d[i] = p_q[i-1];
            end
        end
    end

    // Data-only registers: their reset value is irrelevant, validity lives outside.
    always_ff @(posedge clk) begin
        p_q <= p_d;
    end

    assign p = p_q[STAGES-1];

endmodule

// File: rtl/rat_mul_div_pipe.sv
// rtl/rat_mul_div_pipe.sv - pipelined signed rational mul/div; optional tag passthrough via RAT_MUL_DIV_TAG_EN
module rat_mul_div_pipe
    import rat_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
`ifdef RAT_MUL_DIV_TAG_EN
    ,
    parameter int TAG_WIDTH  = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op_div,
    input  logic [WIDTH-1:0]     l_num,
    input  logic [WIDTH-1:0]     l_den,
    input  logic [WIDTH-1:0]     r_num,
    input  logic [WIDTH-1:0]     r_den,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   s_num,
    output logic [2*WIDTH-1:0]   s_den,
    output logic                 s_err
`ifdef RAT_MUL_DIV_TAG_EN
    ,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic [TAG_WIDTH-1:0] s_tag
`endif
);

    localparam int L = rat_latency(MUL_STAGES);

    logic                      adv;
    logic [L-1:0]              valid_d, valid_q;
    logic [WIDTH-1:0]          an_d, an_q, bn_d, bn_q, ad_d, ad_q, bd_d, bd_q;
    logic signed [2*WIDTH-1:0] prod_n, prod_d;
    logic [2*WIDTH-1:0]        s_num_d, s_num_q, s_den_d, s_den_q;
    logic                      s_err_d, s_err_q;

    // One global advance: the whole pipe moves or holds together.
    assign adv      = !valid_q[L-1] || out_ready;
    assign in_ready = adv;

    // Valid bits shift with the data so bubbles keep their place.
    always_comb begin
        valid_d = valid_q;
        if (adv) begin
            valid_d = {valid_q[L-2:0], in_valid};
        end
    end

    // Input register; a divide is a multiply by the reciprocal of the right operand.
    always_comb begin
        an_d = an_q;
        bn_d = bn_q;
        ad_d = ad_q;
        bd_d = bd_q;
        if (adv && in_valid) begin
            an_d = l_num;
            ad_d = l_den;
            bn_d = (op_div == OP_DIV) ? r_den : r_num;
            bd_d = (op_div == OP_DIV) ? r_num : r_den;
        end
    end

    // Operand registers carry no reset; only the valid bits matter.
    always_ff @(posedge clk) begin
        an_q <= an_d;
        bn_q <= bn_d;
        ad_q <= ad_d;
        bd_q <= bd_d;
    end

    rat_mul_pipe #(.WIDTH(WIDTH), .STAGES(MUL_STAGES)) u_mul_num (
        .clk (clk),
        .en  (adv),
        .a   (an_q),
        .b   (bn_q),
        .p   (prod_n)
    );

    rat_mul_pipe #(.WIDTH(WIDTH), .STAGES(MUL_STAGES)) u_mul_den (
        .clk (clk),
        .en  (adv),
        .a   (ad_q),
        .b   (bd_q),
        .p   (prod_d)
    );

    // Normalise: flag a zero denominator, otherwise force the denominator positive.
    always_comb begin
        s_num_d = s_num_q;
        s_den_d = s_den_q;
        s_err_d = s_err_q;
        if (adv) begin
            if (prod_d == '0) begin
                s_num_d = '0;
                s_den_d = '0;
                s_err_d = 1'b1;
            end else if (prod_d[2*WIDTH-1]) begin
                s_num_d = -prod_n;
                s_den_d = -prod_d;
                s_err_d = 1'b0;
            end else begin
                s_num_d = prod_n;
                s_den_d = prod_d;
                s_err_d = 1'b0;
            end
        end
    end

    // Control and output registers; reset drops every in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            s_num_q <= '0;
            s_den_q <= '0;
            s_err_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            s_num_q <= s_num_d;
            s_den_q <= s_den_d;
            s_err_q <= s_err_d;
        end
    end

    assign out_valid = valid_q[L-1];
    assign s_num     = s_num_q;
    assign s_den     = s_den_q;
    assign s_err     = s_err_q;

`ifdef RAT_MUL_DIV_TAG_EN
    logic [TAG_WIDTH-1:0] tag_d [L];
    logic [TAG_WIDTH-1:0] tag_q [L];

    // Tag rides alongside the operands through every stage.
    always_comb begin
        for (int i = 0; i < L; i++) begin
            tag_d[i] = tag_q[i];
        end
        if (adv) begin
            tag_d[0] = (in_valid) ? in_tag : tag_q[0];
            for (int i = 1; i < L; i++) begin
                tag_d[i] = tag_q[i-1];
            end
        end
    end

    // Tag registers reset so s_tag reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q <= tag_d;
        end
    end

    assign s_tag = tag_q[L-1];
`endif

endmodule

// File: tb/tb_rat_mul_div_pipe.sv
// tb/tb_rat_mul_div_pipe.sv - scoreboard bench for rat_mul_div_pipe
module tb_rat_mul_div_pipe;

    localparam int MS = 2;
    localparam int L  = MS + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        op_div;
    logic [31:0] l_num, l_den, r_num, r_den;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] s_num, s_den;
    logic        s_err;
`ifdef RAT_MUL_DIV_TAG_EN
    logic [3:0]  in_tag;
    logic [3:0]  s_tag;
`endif

    rat_mul_div_pipe #(.WIDTH(32), .MUL_STAGES(MS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_div    (op_div),
        .l_num     (l_num),
        .l_den     (l_den),
        .r_num     (r_num),
        .r_den     (r_den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_num     (s_num),
        .s_den     (s_den),
        .s_err     (s_err)
`ifdef RAT_MUL_DIV_TAG_EN
        ,
        .in_tag    (in_tag),
        .s_tag     (s_tag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] num;
        logic [63:0] den;
        logic        err;
        logic [3:0]  tag;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    int          first_out_cyc = -1;
    int          mode     = 0;
    int          burst_start = 0;
    logic [3:0]  cur_tag  = 4'd0;
    logic        held_v   = 1'b0;
    logic [63:0] h_num, h_den;
    logic        h_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] n, input logic [63:0] d, input logic e);
        exp_t r;
        r.num = n;
        r.den = d;
        r.err = e;
        r.tag = 4'd0;
        return r;
    endfunction

    function automatic exp_t model(input logic div, input int ln, input int ld,
                                   input int rn, input int rd);
        longint an, bn, ad, bd, pn, pd;
        an = longint'(ln);
        ad = longint'(ld);
        bn = div ? longint'(rd) : longint'(rn);
        bd = div ? longint'(rn) : longint'(rd);
        pn = an * bn;
        pd = ad * bd;
        if (pd == 0)     return mk(64'd0, 64'd0, 1'b1);
        else if (pd < 0) return mk(-pn, -pd, 1'b0);
        else             return mk(pn, pd, 1'b0);
    endfunction

    // Output monitor: scoreboard pop, in_ready relation and stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (held_v) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_num", s_num, h_num);
                chk("stall_den", s_den, h_den);
                chk("stall_err", 64'(s_err), 64'(h_err));
            end
            if (out_valid && out_ready) begin
                n_assert++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_out: observed num %0h with empty scoreboard", s_num);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("s_num", s_num, e.num);
                    chk("s_den", s_den, e.den);
                    chk("s_err", 64'(s_err), 64'(e.err));
`ifdef RAT_MUL_DIV_TAG_EN
                    chk("s_tag", 64'(s_tag), 64'(e.tag));
`endif
                end
                if (first_out_cyc < 0) first_out_cyc = cyc;
            end
            held_v = out_valid && !out_ready;
            h_num  = s_num;
            h_den  = s_den;
            h_err  = s_err;
        end
    end

    task automatic set_ready();
        case (mode)
            1:       out_ready = !((cyc - burst_start) >= 5 && (cyc - burst_start) <= 9);
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        set_ready();
    endtask

    task automatic send(input logic op, input logic [31:0] ln, input logic [31:0] ld,
                        input logic [31:0] rn, input logic [31:0] rd, input exp_t e_in);
        exp_t e;
        bit   done;
        e        = e_in;
        e.tag    = cur_tag;
        in_valid = 1'b1;
        op_div   = op;
        l_num    = ln;
        l_den    = ld;
        r_num    = rn;
        r_den    = rd;
`ifdef RAT_MUL_DIV_TAG_EN
        in_tag   = cur_tag;
`endif
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc;
                sb.push_back(e);
                done = 1'b1;
            end
            step();
        end
        n_assert++;
        assert (done) else begin
            n_fail++;
            $error("FAIL accept_timeout: observed no accept expected accept within 100 cycles");
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 300 && sb.size() != 0; k++) step();
        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
        end
    endtask

    task automatic send_rand();
        int ln, ld, rn, rd;
        logic op;
        ln = int'($urandom);
        ld = int'($urandom);
        rn = int'($urandom);
        rd = int'($urandom);
        op = logic'($urandom_range(0, 1));
        send(op, ln, ld, rn, rd, model(op, ln, ld, rn, rd));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        op_div    = 1'b0;
        l_num     = 32'd1;
        l_den     = 32'd1;
        r_num     = 32'd1;
        r_den     = 32'd1;
        out_ready = 1'b1;
`ifdef RAT_MUL_DIV_TAG_EN
        in_tag    = 4'd5;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_s_num", s_num, 64'd0);
        chk("rst_s_den", s_den, 64'd0);
        chk("rst_s_err", 64'(s_err), 64'd0);
`ifdef RAT_MUL_DIV_TAG_EN
        chk("rst_s_tag", 64'(s_tag), 64'd0);
`endif
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        step();

        // Signed multiply with latency measurement.
        send(1'b0, 32'd3, -32'sd4, -32'sd5, 32'd7, mk(64'd15, 64'd28, 1'b0));
        drain();
        chk("latency", 64'(first_out_cyc - acc_cyc), 64'(L));

        // Divides, zero denominators and width extremes, back to back.
        send(1'b1, 32'd2, 32'd3, -32'sd5, 32'd7, mk(-64'sd14, 64'd15, 1'b0));
        send(1'b1, 32'd1, 32'd2, 32'd0, 32'd9, mk(64'd0, 64'd0, 1'b1));
        send(1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd1,
             mk(64'h4000_0000_0000_0000, 64'd1, 1'b0));
        send(1'b0, 32'h8000_0000, 32'd1, 32'd1, 32'h8000_0000,
             mk(64'h8000_0000, 64'h8000_0000, 1'b0));
        send(1'b0, 32'd5, 32'd0, 32'd1, 32'd1, mk(64'd0, 64'd0, 1'b1));
        send(1'b0, 32'd5, 32'd3, 32'd2, 32'd0, mk(64'd0, 64'd0, 1'b1));
        drain();

        // Backpressure window on a stream of 8.
        mode        = 1;
        burst_start = cyc;
        for (int i = 0; i < 8; i++) begin
            cur_tag = 4'(i);
            send_rand();
        end
        drain();
        mode = 0;
        set_ready();

        // Reset in the middle of traffic discards everything.
        send_rand();
        send_rand();
        send_rand();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        #2;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < L + 3; k++) step();
        chk("post_rst_idle", 64'(out_valid), 64'd0);

        // Random stalls with tags 0..7.
        mode = 2;
        for (int i = 0; i < 8; i++) begin
            cur_tag = 4'(i);
            send_rand();
        end
        drain();
        mode = 0;
        set_ready();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rat_mul_div_pipe.md
Name: rat_mul_div_pipe

Overview:
- Pipelined signed rational multiply/divide unit: s = l*r (mul) or s = l/r (div), with a valid/ready handshake.
- Successor to the single-cycle unsigned rational multiplier in hardware/hdl/rat.
- Adds the following over that multiplier:
  - parametrised multiplier pipeline depth;
  - full-width 2*WIDTH products with no truncation;
  - signed operands, with the denominator sign normalised positive;
  - zero-denominator error flag;
  - backpressure.
- Sits between the rational operand scheduler and the reduction/GCD stage.

Parameters:
- WIDTH, 32, operand width; operands are two's-complement signed.
- MUL_STAGES, 2, register stages inside each multiplier (≥1). Total latency L = MUL_STAGES+2.
- TAG_WIDTH, 4, width of the passthrough tag (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  unit accepts operands this cycle.
- op_div  in  1  0 = multiply, 1 = divide.
- l_num  in  WIDTH  left numerator, signed.
- l_den  in  WIDTH  left denominator, signed.
- r_num  in  WIDTH  right numerator, signed.
- r_den  in  WIDTH  right denominator, signed.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- s_num  out  2*WIDTH  result numerator, signed.
- s_den  out  2*WIDTH  result denominator, signed, ≥0.
- s_err  out  1  result denominator is zero; s_num is forced to 0.
- in_tag  in  TAG_WIDTH  (only with RAT_MUL_DIV_TAG_EN) request tag.
- s_tag  out  TAG_WIDTH  (only with RAT_MUL_DIV_TAG_EN) tag returned with its result.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0.
  - out_valid=0, s_num=0, s_den=0, s_err=0, s_tag=0.
  - Data registers inside the pipe are don't-care.
  - Reset asserted mid-operation discards every in-flight result; nothing is emitted after release.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv, combinational. It depends on out_ready, which is the only comb path.
  - Transfer in occurs on in_valid && in_ready. Transfer out occurs on out_valid && out_ready.
  - When adv=0 every stage holds, and outputs are stable until accepted.
  - Bubbles do not collapse. A stage's valid bit advances with adv, like its data.
- Stage 0 (input register), on accept:
  - if op_div=1, latch a_n=l_num, b_n=r_den, a_d=l_den, b_d=r_num;
  - otherwise latch a_n=l_num, b_n=r_num, a_d=l_den, b_d=r_den.
- Stages 1..MUL_STAGES (multiply):
  - p_n = a_n*b_n and p_d = a_d*b_d, both signed, full 2*WIDTH.
  - Products can never overflow.
  - The operands are retimed through MUL_STAGES registers.
- Final stage (normalise), feeds the output registers:
  - If p_d==0: s_err=1, s_num=0, s_den=0.
  - Else if p_d<0: s_num=-p_n, s_den=-p_d. Negation cannot overflow, because |p| ≤ 2^(2W-2).
  - Else: pass p_n and p_d unchanged.
  - s_err=0 whenever p_d≠0.
- Latency: a result appears L=MUL_STAGES+2 cycles after its accept edge when out_ready is held high.
  - Throughput is 1 result per cycle.
  - Order is preserved.
- Simultaneous accept-in and accept-out in the same cycle is legal, and the pipe shifts by one.
- No reduction is performed; the result is not in lowest terms.
- A zero denominator on an input with a nonzero product is impossible. A zero denominator arises only from:
  - l_den=0;
  - mul with r_den=0;
  - div with r_num=0.

Optional Feature:
- Macro: RAT_MUL_DIV_TAG_EN.
- Defined:
  - in_tag and s_tag ports exist.
  - The tag is captured with the operands and travels alongside the data.
  - s_tag is reset to 0.
- Undefined:
  - the ports and tag registers are absent;
  - timing and data behaviour are otherwise identical.

Decomposition:
- Package rat_pkg:
  - OP_MUL=1'b0 and OP_DIV=1'b1 constants;
  - localparam function for latency (MUL_STAGES+2);
  - typedef rat_t {num, den} for WIDTH operands;
  - typedef rat_wide_t for 2*WIDTH results.
- Sub-module rat_mul_pipe (parameters WIDTH, STAGES):
  - a signed pipelined multiplier with a shared enable;
  - instantiated twice, once for the numerator path and once for the denominator path.

Test Plan:
- Reset and hold: rst_n=0 with in_valid=1 → out_valid=0, s_num=0, s_den=0, s_err=0. Release → first output appears only L cycles after the first accept.
- Mul signs: l=3/-4, r=-5/7, out_ready=1 → after L=4 cycles, s_num=15, s_den=28 (raw product is -15/-28, normalised positive), s_err=0.
- Div: l=2/3, r=-5/7, op_div=1 → s_num=-14, s_den=15. Then l=1/2 divided by r=0/9 → s_err=1, s_num=0, s_den=0.
- Width extremes (WIDTH=32): l=-2^31/1, r=-2^31/1, mul → s_num=2^62, s_den=1, no wrap. Also l=-2^31/1, r=1/-2^31, mul → s_num=2^31 (raw -2^31/-2^31), s_den=2^31.
- Backpressure: stream 8 back-to-back ops; out_ready=0 for cycles 5–9, then 1 → in_ready tracks !out_valid||out_ready, outputs are held stable while stalled, all 8 results arrive in order, none dropped or duplicated.
- Tag (RAT_MUL_DIV_TAG_EN): tags 0..7 on 8 ops with random stalls → s_tag matches each result's request. Rebuild without the macro → same data checks pass.
